// File: rtl/rr_mux_n_1.sv
// N-to-1 round-robin collector: merges N valid/ready lanes into one registered
// output beat tagged with its source lane. Optional packet lock via `RR_MUX_LAST_EN.
module rr_mux_n_1 #(
  parameter int N  = 16,
  parameter int DW = 8,
  parameter int SW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [SW-1:0]   out_sel,
  input  logic            out_ready,
`ifdef RR_MUX_LAST_EN
  input  logic [N-1:0]    in_last,
  output logic            out_last,
`endif
  output logic            state_dbg
);

  // Handshake: a beat moves on any rising edge where valid and ready are both 1;
  // valid never waits on ready, and in_ready is raised for at most one lane.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] ptr_nxt;
  logic [SW-1:0] grant_idx;
  logic          grant_found;
  logic [SW:0]   cand;
  logic [SW-1:0] cand_idx;
  logic          load;
  logic          accept;
  logic [DW-1:0] win_data;

`ifdef RR_MUX_LAST_EN
  logic          lock_q;
  logic [SW-1:0] lock_lane_q;
`endif

  assign out_valid = (state_q == FULL);
  assign state_dbg = state_q;
  assign load      = ~out_valid | out_ready;

  // Rotating priority search starting at ptr; cand never exceeds 2N-2.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_idx    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (SW+1)'(k);
      if (cand >= (SW+1)'(N)) cand = cand - (SW+1)'(N);
      cand_idx = cand[SW-1:0];
      if (!grant_found && in_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
`ifdef RR_MUX_LAST_EN
    // Mid-packet the held lane is the only candidate, even when it idles.
    if (lock_q) begin
      grant_found = in_valid[lock_lane_q];
      grant_idx   = lock_lane_q;
    end
`endif
  end

  // rst_n gates the grant so no lane sees in_ready while reset is asserted.
  assign accept   = load & grant_found & rst_n;
  assign win_data = in_data[grant_idx*DW +: DW];
  assign ptr_nxt  = (grant_idx == SW'(N-1)) ? '0 : grant_idx + SW'(1);

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data <= win_data;
        out_sel  <= grant_idx;
        ptr_q    <= ptr_nxt;
      end
    end
  end

`ifdef RR_MUX_LAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      lock_lane_q <= '0;
      out_last    <= 1'b0;
    end else if (accept) begin
      lock_q      <= ~in_last[grant_idx];
      lock_lane_q <= grant_idx;
      out_last    <= in_last[grant_idx];
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_n_1.sv
// Directed bench for rr_mux_n_1 (N=16, DW=8, SW=4); the packet-lock scenario
// is compiled in when RR_MUX_LAST_EN is defined.
module tb_rr_mux_n_1;
  localparam int N  = 16;
  localparam int DW = 8;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;
  logic            state_dbg;
`ifdef RR_MUX_LAST_EN
  logic [N-1:0]    in_last;
  logic            out_last;
`endif

  logic [DW-1:0]   lane_d [N];
  logic [SW-1:0]   exp_q [$];
  logic [SW-1:0]   exp_sel;
  logic [N-1:0]    exp_rdy;
  int              n_checks = 0;
  int              n_pass   = 0;

  rr_mux_n_1 #(.N(N), .DW(DW), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
`ifdef RR_MUX_LAST_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_data();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = lane_d[i];
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (out_sel !== 4'd0) $display("FAIL reset_sel got=%0d exp=0", out_sel); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", out_data); else n_pass++;
    n_checks++; if (in_ready !== 16'h0000) $display("FAIL reset_in_ready got=%h exp=0000", in_ready); else n_pass++;
    n_checks++; if (state_dbg !== 1'b0) $display("FAIL reset_state got=%b exp=0", state_dbg); else n_pass++;
    in_valid = '0;
    rst_n    = 1'b1;
    #1;
  endtask

  task automatic test_fairness();
    in_valid  = '1;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k <= N; k++) begin
      exp_rdy = 16'h0001 << (k % N);
      n_checks++; if (in_ready !== exp_rdy) $display("FAIL fair_in_ready[%0d] got=%h exp=%h", k, in_ready, exp_rdy); else n_pass++;
      exp_q.push_back(SW'(k % N));
      tick();
      exp_sel = exp_q.pop_front();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL fair_valid[%0d] got=%b exp=1", k, out_valid); else n_pass++;
      n_checks++; if (out_sel !== exp_sel) $display("FAIL fair_sel[%0d] got=%0d exp=%0d", k, out_sel, exp_sel); else n_pass++;
      n_checks++; if (out_data !== 8'h30 + 8'(exp_sel)) $display("FAIL fair_data[%0d] got=%h exp=%h", k, out_data, 8'h30 + 8'(exp_sel)); else n_pass++;
    end
    in_valid = '0;
    #1;
    n_checks++; if (in_ready !== 16'h0000) $display("FAIL idle_in_ready got=%h exp=0000", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (out_sel !== 4'd0 || out_data !== 8'h30) $display("FAIL drain_hold got=%0d/%h exp=0/30", out_sel, out_data); else n_pass++;
  endtask

  task automatic test_sparse();
    logic [SW-1:0] seq [4];
    seq[0] = 4'd3; seq[1] = 4'd12; seq[2] = 4'd3; seq[3] = 4'd12;
    do_reset();
    in_valid  = 16'h1008;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = 16'h0001 << seq[k];
      n_checks++; if (in_ready !== exp_rdy) $display("FAIL sparse_in_ready[%0d] got=%h exp=%h", k, in_ready, exp_rdy); else n_pass++;
      tick();
      n_checks++; if (out_sel !== seq[k]) $display("FAIL sparse_sel[%0d] got=%0d exp=%0d", k, out_sel, seq[k]); else n_pass++;
      n_checks++; if (out_data !== 8'h30 + 8'(seq[k])) $display("FAIL sparse_data[%0d] got=%h exp=%h", k, out_data, 8'h30 + 8'(seq[k])); else n_pass++;
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    lane_d[7] = 8'hA5;
    pack_data();
    out_ready = 1'b0;
    in_valid  = 16'h0080;
    #1;
    n_checks++; if (in_ready !== 16'h0080) $display("FAIL bp_grant7 got=%h exp=0080", in_ready); else n_pass++;
    tick();
    in_valid = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 4'd7)
        $display("FAIL bp_stall_out[%0d] got=%b/%h/%0d exp=1/a5/7", k, out_valid, out_data, out_sel); else n_pass++;
      n_checks++; if (in_ready !== 16'h0000) $display("FAIL bp_stall_in_ready[%0d] got=%h exp=0000", k, in_ready); else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 16'h0100) $display("FAIL bp_release_in_ready got=%h exp=0100", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_sel !== 4'd8 || out_data !== 8'h38) $display("FAIL bp_release_out got=%0d/%h exp=8/38", out_sel, out_data); else n_pass++;
    lane_d[7] = 8'h37;
    pack_data();
    in_valid = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 16'h0020;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_sel !== 4'd5) $display("FAIL ar_pre got=%b/%0d exp=1/5", out_valid, out_sel); else n_pass++;
    n_checks++; if (in_ready !== 16'h0020) $display("FAIL ar_grant5 got=%h exp=0020", in_ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_sel !== 4'd0) $display("FAIL ar_immediate got=%b/%0d exp=0/0", out_valid, out_sel); else n_pass++;
    n_checks++; if (in_ready !== 16'h0000) $display("FAIL ar_in_ready got=%h exp=0000", in_ready); else n_pass++;
    tick();
    n_checks++; if (in_ready !== 16'h0000 || out_valid !== 1'b0) $display("FAIL ar_held got=%h/%b exp=0000/0", in_ready, out_valid); else n_pass++;
    in_valid = 16'h0204;
    rst_n    = 1'b1;
    #1;
    n_checks++; if (in_ready !== 16'h0004) $display("FAIL ar_ptr0_grant got=%h exp=0004", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_sel !== 4'd2 || out_data !== 8'h32) $display("FAIL ar_first_out got=%0d/%h exp=2/32", out_sel, out_data); else n_pass++;
    in_valid = '0;
    tick();
  endtask

`ifdef RR_MUX_LAST_EN
  task automatic test_packet_lock();
    logic [2:0] lasts;
    lasts = 3'b100;
    do_reset();
    out_ready = 1'b1;
    in_last   = '0;
    for (int b = 0; b < 3; b++) begin
      in_valid   = 16'h0204;
      in_last[2] = lasts[b];
      #1;
      n_checks++; if (in_ready !== 16'h0004) $display("FAIL lock_in_ready[%0d] got=%h exp=0004", b, in_ready); else n_pass++;
      tick();
      n_checks++; if (out_sel !== 4'd2 || out_last !== lasts[b]) $display("FAIL lock_out[%0d] got=%0d/%b exp=2/%b", b, out_sel, out_last, lasts[b]); else n_pass++;
      if (b == 0) begin
        in_valid = 16'h0200;
        #1;
        n_checks++; if (in_ready !== 16'h0000) $display("FAIL lock_idle_in_ready got=%h exp=0000", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL lock_idle_valid got=%b exp=0", out_valid); else n_pass++;
      end
    end
    in_valid = 16'h0200;
    in_last  = '0;
    #1;
    n_checks++; if (in_ready !== 16'h0200) $display("FAIL unlock_in_ready got=%h exp=0200", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_sel !== 4'd9 || out_last !== 1'b0) $display("FAIL unlock_out got=%0d/%b exp=9/0", out_sel, out_last); else n_pass++;
    in_valid = '0;
    tick();
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
`ifdef RR_MUX_LAST_EN
    in_last   = '0;
`endif
    for (int i = 0; i < N; i++) lane_d[i] = 8'h30 + 8'(i);
    pack_data();
    test_reset();
    test_fairness();
    test_sparse();
    test_backpressure();
    test_async_reset();
`ifdef RR_MUX_LAST_EN
    test_packet_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
